clkdiv_gated: RTL
=================

CLKDIV_GATED -- requirements
Module: clkdiv_gated

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent divided-clock channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 4, bit width of each channel's divide ratio (2..8).
REQ-003 SHALL have parameter DIV_RST, default 2, active ratio loaded at reset (2..2^WIDTH-1).
REQ-004 SHALL have port CLK  input  1  source clock; all logic rising-edge triggered.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port EN  input  NCH  per-channel run request.
REQ-007 SHALL have port DIV  input  NCH*WIDTH  per-channel requested ratio; channel k uses bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port LD  input  NCH  per-channel single-cycle load strobe for DIV.
REQ-009 SHALL have port ACK  output  NCH  per-channel single-cycle pulse when a loaded ratio becomes active.
REQ-010 SHALL have port Z  output  NCH  per-channel divided clock, driven directly from a flop.
REQ-011 SHALL have ports VDD and VSS  inout  1  supply pins, no functional use.

Function
REQ-012 Effective ratio R SHALL equal the active ratio register, with any DIV value of 0 or 1 clamped to 2 at load time.
REQ-013 Each channel SHALL have states IDLE and RUN, plus one pending-load flag and a WIDTH-bit counter CNT.
REQ-014 In IDLE, Z SHALL be 0 and CNT SHALL be 0.
REQ-015 IDLE -> RUN SHALL occur on the first CLK edge with EN=1; Z SHALL be 1 from that edge (CNT=0).
REQ-016 In RUN, CNT SHALL increment each cycle and wrap from R-1 to 0; Z SHALL be 1 while CNT < floor(R/2), else 0.
REQ-017 Period SHALL be exactly R CLK cycles; high phase floor(R/2), low phase ceil(R/2).
REQ-018 EN falling in RUN SHALL NOT truncate a period; the channel SHALL return to IDLE at the edge where CNT would wrap to 0.
REQ-019 EN re-asserted before that wrap SHALL cancel the stop, giving continuous periods.
REQ-020 LD=1 SHALL capture DIV into the pending register and set the pending flag; a later LD before application SHALL overwrite pending and yield a single ACK.
REQ-021 A pending ratio SHALL become active at the next period boundary (CNT wrap) in RUN, or on the next edge in IDLE.
REQ-022 LD in the same cycle as a boundary (CNT=R-1) SHALL have its value applied at that boundary.
REQ-023 ACK SHALL pulse high for exactly one cycle on the edge the active ratio is updated.
REQ-024 A ratio change SHALL never produce a Z high or low phase shorter than floor of either the old or new R/2.
REQ-025 Channels SHALL be fully independent; no cross-channel timing relationship is guaranteed beyond sharing CLK.

Reset
REQ-026 While RST=1: Z=0, ACK=0, state=IDLE, CNT=0, pending flag=0, active ratio=DIV_RST, asynchronously.
REQ-027 RST asserted mid-period SHALL force Z low immediately; pending loads SHALL be discarded without ACK.
REQ-028 First functional edge SHALL be the first CLK rising edge after RST deasserts.

Structure
REQ-029 A shared package SHALL hold the channel state enum (IDLE, RUN) and constant RATIO_MIN=2.
REQ-030 One sub-module clkdiv_chan SHALL implement a single channel; the top SHALL instantiate NCH copies via generate.

Verification
REQ-031 Reset, EN[0]=1, R=2 -> Z[0] toggles every cycle starting high on first edge; Z[1] stays 0.
REQ-032 DIV=5 loaded while IDLE -> ACK next edge; EN=1 -> Z high 2 cycles, low 3, period 5, repeated.
REQ-033 Running R=4, LD with DIV=7 at CNT=1 -> current period completes with 2H/2L, ACK at wrap, then 3H/4L.
REQ-034 Running R=6, EN dropped at CNT=1 -> Z completes 3H/3L, channel IDLE, Z stays 0; no short pulse.
REQ-035 LD DIV=0 then LD DIV=9 before boundary -> single ACK, ratio 9; separately LD DIV=1 -> ratio clamps to 2.
REQ-036 RST asserted at CNT=2 of R=8 with pending load -> Z=0 immediately, no ACK; after release ratio=DIV_RST.

Source files
------------

// File: rtl/clkdiv_gated_pkg.sv
// Shared definitions for the gated clock divider: per-channel state encoding
// and the smallest ratio a channel can run at.
package clkdiv_gated_pkg;

    // Channel run state; a channel is either parked low or producing periods.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // Smallest usable divide ratio; DIV values below this are clamped up.
    localparam int RATIO_MIN = 2;

endpackage : clkdiv_gated_pkg

// File: rtl/clkdiv_gated_chan.sv
// One divided-clock channel. Z is high for floor(R/2) cycles and low for
// ceil(R/2) cycles of every R-cycle period. Stops and ratio changes only take
// effect at a period boundary, so no shortened phase is ever emitted.
module clkdiv_chan
    import clkdiv_gated_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             ld,
    output logic             ack,
    output logic             z
);

    localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] RATIO_LO  = WIDTH'(RATIO_MIN);

    // Ratios 0 and 1 cannot form a high and a low phase; force them to the minimum.
    function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] v);
        if (v < RATIO_LO) begin
            clamp_ratio = RATIO_LO;
        end else begin
            clamp_ratio = v;
        end
    endfunction

    chan_state_t      state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] ratio_r, ratio_s;
    logic [WIDTH-1:0] pend_r, pend_s;
    logic             pend_flag_r, pend_flag_s;
    logic             z_r, z_s;
    logic             ack_r, ack_s;
    logic             wrap_s;
    logic             apply_pend_s;
    logic [WIDTH-1:0] ld_val_s;
    logic [WIDTH-1:0] cnt_inc_s;

    // Next-state logic: period counter, output phase and ratio hand-over.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ratio_s      = ratio_r;
        pend_s       = pend_r;
        pend_flag_s  = pend_flag_r;
        z_s          = 1'b0;
        ack_s        = 1'b0;
        ld_val_s     = clamp_ratio(div);
        cnt_inc_s    = cnt_r + WIDTH'(1);
        wrap_s       = (state_r == ST_RUN) && (cnt_r == (ratio_r - WIDTH'(1)));
        apply_pend_s = pend_flag_r && ((state_r == ST_IDLE) || wrap_s);

        case (state_r)
            ST_IDLE: begin
                cnt_s = WIDTH'(0);
                if (en) begin
                    state_s = ST_RUN;
                    z_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    z_s     = 1'b0;
                end
            end
            ST_RUN: begin
                if (wrap_s) begin
                    // Boundary: either start the next period high or park.
                    cnt_s = WIDTH'(0);
                    if (en) begin
                        state_s = ST_RUN;
                        z_s     = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        z_s     = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                    z_s   = (cnt_inc_s < (ratio_r >> 1));
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = WIDTH'(0);
                z_s     = 1'b0;
            end
        endcase

        // A load seen on the boundary edge is applied there directly and
        // supersedes any older pending value, so only one ACK results.
        if (wrap_s && ld) begin
            ratio_s     = ld_val_s;
            pend_flag_s = 1'b0;
            ack_s       = 1'b1;
        end else if (apply_pend_s) begin
            ratio_s = pend_r;
            ack_s   = 1'b1;
            if (ld) begin
                pend_s      = ld_val_s;
                pend_flag_s = 1'b1;
            end else begin
                pend_flag_s = 1'b0;
            end
        end else if (ld) begin
            pend_s      = ld_val_s;
            pend_flag_s = 1'b1;
        end else begin
            pend_flag_s = pend_flag_r;
        end
    end

    // State register; reset parks the channel low and drops pending loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= WIDTH'(0);
            ratio_r     <= RATIO_RST;
            pend_r      <= RATIO_RST;
            pend_flag_r <= 1'b0;
            z_r         <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ratio_r     <= ratio_s;
            pend_r      <= pend_s;
            pend_flag_r <= pend_flag_s;
            z_r         <= z_s;
            ack_r       <= ack_s;
        end
    end

    assign z   = z_r;
    assign ack = ack_r;

endmodule : clkdiv_chan

// File: rtl/clkdiv_gated.sv
// Multi-channel gated clock divider: NCH independent copies of clkdiv_chan
// sharing one source clock and reset.
module clkdiv_gated
    import clkdiv_gated_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int WIDTH   = 4,
    parameter int DIV_RST = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*WIDTH-1:0] DIV,
    input  logic [NCH-1:0]       LD,
    output logic [NCH-1:0]       ACK,
    output logic [NCH-1:0]       Z,
    inout  wire                  VDD,
    inout  wire                  VSS
);

    // Supply pins carry no logic; fold them into a sink so they stay connected.
    logic unused_supply_s;
    assign unused_supply_s = VDD ^ VSS;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_chan
            clkdiv_chan #(
                .WIDTH   (WIDTH),
                .DIV_RST (DIV_RST)
            ) u_chan (
                .clk (CLK),
                .rst (RST),
                .en  (EN[k]),
                .div (DIV[k*WIDTH +: WIDTH]),
                .ld  (LD[k]),
                .ack (ACK[k]),
                .z   (Z[k])
            );
        end
    endgenerate

endmodule : clkdiv_gated
